// File: rtl/hilo_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_decode_stage_if
//  Description : Fetch-side handshake, flush and ID/EX control-word bundle
//                for the registered decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface hilo_decode_stage_if;
    // fetch side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    // execute side
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  aluop;
    logic [1:0]  alusrc;
    logic [1:0]  hilowrite;
    logic        regwrite;
    logic        regdst;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
    logic        bal;
    logic        jump;
    logic        jal;
    logic        jr;
    logic        jalr;
    logic        ri;
    logic        hilo_busy;

    // surrounding pipeline: drives instructions, flush and EX consumption
    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, aluop, alusrc, hilowrite, regwrite, regdst,
               memwrite, memtoreg, branch, bal, jump, jal, jr, jalr, ri, hilo_busy
    );

    // decode stage itself
    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, aluop, alusrc, hilowrite, regwrite, regdst,
               memwrite, memtoreg, branch, bal, jump, jal, jr, jalr, ri, hilo_busy
    );
endinterface
`default_nettype wire

// File: rtl/hilo_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_decode_stage
//  Description : Registered MIPS decode stage. Decodes one instruction per
//                cycle into an ID/EX control register with valid/ready and
//                flush, flags reserved instructions and stalls HI/LO users
//                while a multiply/divide is still occupying HI/LO.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_decode_stage #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 34
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    hilo_decode_stage_if.slave bus
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'hA;
    localparam logic [3:0] ALU_LUI  = 4'hB;

    typedef struct packed {
        logic [3:0] aluop;
        logic [1:0] alusrc;
        logic [1:0] hilowrite;
        logic       regwrite;
        logic       regdst;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       bal;
        logic       jump;
        logic       jal;
        logic       jr;
        logic       jalr;
        logic       ri;
    } ctrl_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       unused_instr_bits;

    ctrl_t      dec_d;
    ctrl_t      ctrl_q;
    logic       rtype_alu;
    logic       dec_mul;
    logic       dec_div;
    logic       hilo_cls;

    logic       out_valid_q;
    logic       out_valid_d;
    logic       is_mul_q;
    logic       is_div_q;
    logic [5:0] cnt_q;
    logic [5:0] cnt_d;

    logic       hilo_busy;
    logic       in_ready;
    logic       accept;
    logic       handoff;

    assign op                = bus.instr[31:26];
    assign rt                = bus.instr[20:16];
    assign funct             = bus.instr[5:0];
    assign unused_instr_bits = ^{bus.instr[25:21], bus.instr[15:6]};

    // HI/LO-touching instructions: MFHI/MTHI/MFLO/MTLO (10-13) and MULT..DIVU (18-1B)
    assign hilo_cls = (op == OP_SPECIAL) &&
                      ((funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110));

    assign hilo_busy = (cnt_q != 6'd0) | (out_valid_q & (is_mul_q | is_div_q));
    assign in_ready  = ~bus.flush & (~out_valid_q | bus.out_ready) & ~(hilo_busy & hilo_cls);
    assign accept    = bus.in_valid & in_ready;
    // a flush discards the entry, so it never counts as consumed by EX
    assign handoff   = out_valid_q & bus.out_ready & ~bus.flush;

    // Combinational instruction decode into the control word
    always_comb begin
        dec_d     = '0;
        rtype_alu = 1'b0;
        dec_mul   = 1'b0;
        dec_div   = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    6'h00, 6'h04: begin dec_d.aluop = ALU_SLL;  rtype_alu = 1'b1; end
                    6'h02, 6'h06: begin dec_d.aluop = ALU_SRL;  rtype_alu = 1'b1; end
                    6'h03, 6'h07: begin dec_d.aluop = ALU_SRA;  rtype_alu = 1'b1; end
                    6'h08:        dec_d.jr = 1'b1;
                    6'h09:        begin dec_d.jalr = 1'b1; rtype_alu = 1'b1; end
                    6'h0C, 6'h0D: ; // SYSCALL/BREAK: legal, no datapath controls
                    6'h10, 6'h12: rtype_alu = 1'b1;
                    6'h11:        dec_d.hilowrite = 2'b10;
                    6'h13:        dec_d.hilowrite = 2'b01;
                    6'h18, 6'h19: begin dec_d.hilowrite = 2'b11; dec_mul = 1'b1; end
                    6'h1A, 6'h1B: begin dec_d.hilowrite = 2'b11; dec_div = 1'b1; end
                    6'h20, 6'h21: begin dec_d.aluop = ALU_ADD;  rtype_alu = 1'b1; end
                    6'h22, 6'h23: begin dec_d.aluop = ALU_SUB;  rtype_alu = 1'b1; end
                    6'h24:        begin dec_d.aluop = ALU_AND;  rtype_alu = 1'b1; end
                    6'h25:        begin dec_d.aluop = ALU_OR;   rtype_alu = 1'b1; end
                    6'h26:        begin dec_d.aluop = ALU_XOR;  rtype_alu = 1'b1; end
                    6'h27:        begin dec_d.aluop = ALU_NOR;  rtype_alu = 1'b1; end
                    6'h2A:        begin dec_d.aluop = ALU_SLT;  rtype_alu = 1'b1; end
                    6'h2B:        begin dec_d.aluop = ALU_SLTU; rtype_alu = 1'b1; end
                    default:      dec_d.ri = 1'b1;
                endcase
                if (rtype_alu) begin
                    dec_d.regwrite = 1'b1;
                    dec_d.regdst   = 1'b1;
                end
            end
            OP_REGIMM: begin
                case (rt)
                    5'h00, 5'h01: begin dec_d.aluop = ALU_SUB; dec_d.branch = 1'b1; end
                    5'h10, 5'h11: begin
                        dec_d.aluop    = ALU_SUB;
                        dec_d.branch   = 1'b1;
                        dec_d.bal      = 1'b1;
                        dec_d.regwrite = 1'b1;
                    end
                    default:      dec_d.ri = 1'b1;
                endcase
            end
            6'h02: dec_d.jump = 1'b1;
            6'h03: begin dec_d.jal = 1'b1; dec_d.regwrite = 1'b1; end
            6'h04, 6'h05, 6'h06, 6'h07: begin dec_d.aluop = ALU_SUB; dec_d.branch = 1'b1; end
            6'h08, 6'h09: begin dec_d.aluop = ALU_ADD;  dec_d.alusrc = 2'b01; dec_d.regwrite = 1'b1; end
            6'h0A:        begin dec_d.aluop = ALU_SLT;  dec_d.alusrc = 2'b01; dec_d.regwrite = 1'b1; end
            6'h0B:        begin dec_d.aluop = ALU_SLTU; dec_d.alusrc = 2'b01; dec_d.regwrite = 1'b1; end
            6'h0C:        begin dec_d.aluop = ALU_AND;  dec_d.alusrc = 2'b10; dec_d.regwrite = 1'b1; end
            6'h0D:        begin dec_d.aluop = ALU_OR;   dec_d.alusrc = 2'b10; dec_d.regwrite = 1'b1; end
            6'h0E:        begin dec_d.aluop = ALU_XOR;  dec_d.alusrc = 2'b10; dec_d.regwrite = 1'b1; end
            6'h0F:        begin dec_d.aluop = ALU_LUI;  dec_d.alusrc = 2'b10; dec_d.regwrite = 1'b1; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                dec_d.alusrc   = 2'b01;
                dec_d.regwrite = 1'b1;
                dec_d.memwrite = 1'b1; // acts as the memory enable for loads
                dec_d.memtoreg = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: begin dec_d.alusrc = 2'b01; dec_d.memwrite = 1'b1; end
            default: dec_d.ri = 1'b1;
        endcase
    end

    // Next value of the ID/EX valid flag; flush dominates everything
    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.flush)    out_valid_d = 1'b0;
        else if (accept)  out_valid_d = 1'b1;
        else if (handoff) out_valid_d = 1'b0;
    end

    // ID/EX pipeline register; control word only changes on acceptance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            is_mul_q    <= 1'b0;
            is_div_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                ctrl_q   <= dec_d;
                is_mul_q <= dec_mul;
                is_div_q <= dec_div;
            end
        end
    end

    // HI/LO occupancy: load on mult/div handoff, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (handoff && is_mul_q)      cnt_d = 6'(MUL_CYCLES);
        else if (handoff && is_div_q) cnt_d = 6'(DIV_CYCLES);
        else if (cnt_q != 6'd0)       cnt_d = cnt_q - 6'd1;
    end

    // HI/LO occupancy counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= 6'd0;
        else         cnt_q <= cnt_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.hilo_busy = hilo_busy;
    assign bus.aluop     = ctrl_q.aluop;
    assign bus.alusrc    = ctrl_q.alusrc;
    assign bus.hilowrite = ctrl_q.hilowrite;
    assign bus.regwrite  = ctrl_q.regwrite;
    assign bus.regdst    = ctrl_q.regdst;
    assign bus.memwrite  = ctrl_q.memwrite;
    assign bus.memtoreg  = ctrl_q.memtoreg;
    assign bus.branch    = ctrl_q.branch;
    assign bus.bal       = ctrl_q.bal;
    assign bus.jump      = ctrl_q.jump;
    assign bus.jal       = ctrl_q.jal;
    assign bus.jr        = ctrl_q.jr;
    assign bus.jalr      = ctrl_q.jalr;
    assign bus.ri        = ctrl_q.ri;
endmodule
`default_nettype wire

// File: tb/tb_hilo_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_decode_stage
//  Description : Self-checking bench for hilo_decode_stage: directed scenarios
//                followed by random traffic, all against a table-driven model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_decode_stage;
    localparam int MUL_CYC = 2;
    localparam int DIV_CYC = 34;

    localparam logic [31:0] I_ADDIU = 32'h24010005;
    localparam logic [31:0] I_ORI   = 32'h34220007;
    localparam logic [31:0] I_SW    = 32'hAC220000;
    localparam logic [31:0] I_DIV   = 32'h0022001A;
    localparam logic [31:0] I_MULT  = 32'h00220018;
    localparam logic [31:0] I_MFLO  = 32'h00001012;
    localparam logic [31:0] I_MFHI  = 32'h00001010;
    localparam logic [31:0] I_ADDU  = 32'h00221821;

    // control word layout: {aluop, alusrc, hilowrite, 11 single-bit flags}
    localparam logic [10:0] F_RW   = 11'h400;
    localparam logic [10:0] F_RD   = 11'h200;
    localparam logic [10:0] F_MW   = 11'h100;
    localparam logic [10:0] F_MR   = 11'h080;
    localparam logic [10:0] F_BR   = 11'h040;
    localparam logic [10:0] F_BAL  = 11'h020;
    localparam logic [10:0] F_J    = 11'h010;
    localparam logic [10:0] F_JAL  = 11'h008;
    localparam logic [10:0] F_JR   = 11'h004;
    localparam logic [10:0] F_JALR = 11'h002;
    localparam logic [18:0] RI_WORD = 19'h00001;

    localparam logic [3:0] A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2, A_OR  = 4'h3;
    localparam logic [3:0] A_XOR = 4'h4, A_NOR = 4'h5, A_SLT = 4'h6, A_SLTU = 4'h7;
    localparam logic [3:0] A_SLL = 4'h8, A_SRL = 4'h9, A_SRA = 4'hA, A_LUI = 4'hB;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    hilo_decode_stage_if bus_if ();

    hilo_decode_stage #(
        .MUL_CYCLES (MUL_CYC),
        .DIV_CYCLES (DIV_CYC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [18:0] rtab [int];
    logic [18:0] itab [int];

    logic        m_valid;
    logic [18:0] m_word;
    int          m_kind;       // 0 none, 1 multiply, 2 divide
    int          m_edge;
    int          m_busy_until; // HI/LO free once m_edge reaches this value

    function automatic logic [18:0] mk(input logic [3:0] a, input logic [1:0] s,
                                       input logic [1:0] h, input logic [10:0] f);
        return {a, s, h, f};
    endfunction

    task automatic build_tables();
        rtab['h00] = mk(A_SLL, 2'b00, 2'b00, F_RW | F_RD);
        rtab['h04] = mk(A_SLL, 2'b00, 2'b00, F_RW | F_RD);
        rtab['h02] = mk(A_SRL, 2'b00, 2'b00, F_RW | F_RD);
        rtab['h06] = mk(A_SRL, 2'b00, 2'b00, F_RW | F_RD);
        rtab['h03] = mk(A_SRA, 2'b00, 2'b00, F_RW | F_RD);
        rtab['h07] = mk(A_SRA, 2'b00, 2'b00, F_RW | F_RD);
        rtab['h08] = mk(A_ADD, 2'b00, 2'b00, F_JR);
        rtab['h09] = mk(A_ADD, 2'b00, 2'b00, F_RW | F_RD | F_JALR);
        rtab['h0C] = 19'h0;
        rtab['h0D] = 19'h0;
        rtab['h10] = mk(A_ADD, 2'b00, 2'b00, F_RW | F_RD);
        rtab['h12] = mk(A_ADD, 2'b00, 2'b00, F_RW | F_RD);
        rtab['h11] = mk(A_ADD, 2'b00, 2'b10, 11'h0);
        rtab['h13] = mk(A_ADD, 2'b00, 2'b01, 11'h0);
        for (int f = 'h18; f <= 'h1B; f++) rtab[f] = mk(A_ADD, 2'b00, 2'b11, 11'h0);
        rtab['h20] = mk(A_ADD,  2'b00, 2'b00, F_RW | F_RD);
        rtab['h21] = mk(A_ADD,  2'b00, 2'b00, F_RW | F_RD);
        rtab['h22] = mk(A_SUB,  2'b00, 2'b00, F_RW | F_RD);
        rtab['h23] = mk(A_SUB,  2'b00, 2'b00, F_RW | F_RD);
        rtab['h24] = mk(A_AND,  2'b00, 2'b00, F_RW | F_RD);
        rtab['h25] = mk(A_OR,   2'b00, 2'b00, F_RW | F_RD);
        rtab['h26] = mk(A_XOR,  2'b00, 2'b00, F_RW | F_RD);
        rtab['h27] = mk(A_NOR,  2'b00, 2'b00, F_RW | F_RD);
        rtab['h2A] = mk(A_SLT,  2'b00, 2'b00, F_RW | F_RD);
        rtab['h2B] = mk(A_SLTU, 2'b00, 2'b00, F_RW | F_RD);

        itab['h02] = mk(A_ADD, 2'b00, 2'b00, F_J);
        itab['h03] = mk(A_ADD, 2'b00, 2'b00, F_JAL | F_RW);
        for (int o = 'h04; o <= 'h07; o++) itab[o] = mk(A_SUB, 2'b00, 2'b00, F_BR);
        itab['h08] = mk(A_ADD,  2'b01, 2'b00, F_RW);
        itab['h09] = mk(A_ADD,  2'b01, 2'b00, F_RW);
        itab['h0A] = mk(A_SLT,  2'b01, 2'b00, F_RW);
        itab['h0B] = mk(A_SLTU, 2'b01, 2'b00, F_RW);
        itab['h0C] = mk(A_AND,  2'b10, 2'b00, F_RW);
        itab['h0D] = mk(A_OR,   2'b10, 2'b00, F_RW);
        itab['h0E] = mk(A_XOR,  2'b10, 2'b00, F_RW);
        itab['h0F] = mk(A_LUI,  2'b10, 2'b00, F_RW);
        itab['h20] = mk(A_ADD, 2'b01, 2'b00, F_RW | F_MW | F_MR);
        itab['h21] = mk(A_ADD, 2'b01, 2'b00, F_RW | F_MW | F_MR);
        itab['h23] = mk(A_ADD, 2'b01, 2'b00, F_RW | F_MW | F_MR);
        itab['h24] = mk(A_ADD, 2'b01, 2'b00, F_RW | F_MW | F_MR);
        itab['h25] = mk(A_ADD, 2'b01, 2'b00, F_RW | F_MW | F_MR);
        itab['h28] = mk(A_ADD, 2'b01, 2'b00, F_MW);
        itab['h29] = mk(A_ADD, 2'b01, 2'b00, F_MW);
        itab['h2B] = mk(A_ADD, 2'b01, 2'b00, F_MW);
    endtask

    function automatic logic [18:0] ref_decode(input logic [31:0] ins);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        int rt = int'(ins[20:16]);
        if (op == 0) return rtab.exists(fn) ? rtab[fn] : RI_WORD;
        if (op == 1) begin
            if (rt == 0 || rt == 1)   return mk(A_SUB, 2'b00, 2'b00, F_BR);
            if (rt == 16 || rt == 17) return mk(A_SUB, 2'b00, 2'b00, F_BR | F_BAL | F_RW);
            return RI_WORD;
        end
        return itab.exists(op) ? itab[op] : RI_WORD;
    endfunction

    function automatic int ref_kind(input logic [31:0] ins);
        if (ins[31:26] != 6'h00) return 0;
        if (ins[5:0] == 6'h18 || ins[5:0] == 6'h19) return 1;
        if (ins[5:0] == 6'h1A || ins[5:0] == 6'h1B) return 2;
        return 0;
    endfunction

    function automatic bit ref_hilo_touch(input logic [31:0] ins);
        return (ins[31:26] == 6'h00) &&
               (ins[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic logic [18:0] obs_word();
        return {bus_if.aluop, bus_if.alusrc, bus_if.hilowrite, bus_if.regwrite,
                bus_if.regdst, bus_if.memwrite, bus_if.memtoreg, bus_if.branch,
                bus_if.bal, bus_if.jump, bus_if.jal, bus_if.jr, bus_if.jalr, bus_if.ri};
    endfunction

    task automatic model_reset();
        m_valid      = 1'b0;
        m_word       = '0;
        m_kind       = 0;
        m_busy_until = 0;
        m_edge       = 0;
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                        input logic ordy, output logic rdy);
        logic exp_busy, exp_rdy, acc, ho;
        exp_busy = (m_edge < m_busy_until) || (m_valid && m_kind != 0);
        check("out_valid", 32'(bus_if.out_valid), 32'(m_valid));
        check("ctrl_word", 32'(obs_word()), 32'(m_word));
        check("hilo_busy", 32'(bus_if.hilo_busy), 32'(exp_busy));
        bus_if.in_valid  = v;
        bus_if.instr     = ins;
        bus_if.flush     = fl;
        bus_if.out_ready = ordy;
        #1;
        exp_rdy = !fl && (!m_valid || ordy) && !(exp_busy && ref_hilo_touch(ins));
        rdy     = bus_if.in_ready;
        check("in_ready", 32'(rdy), 32'(exp_rdy));
        acc = v && exp_rdy;
        ho  = m_valid && ordy && !fl;
        @(posedge clk);
        m_edge++;
        if (ho && m_kind == 1) m_busy_until = m_edge + MUL_CYC;
        if (ho && m_kind == 2) m_busy_until = m_edge + DIV_CYC;
        if (fl) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_word  = ref_decode(ins);
            m_kind  = ref_kind(ins);
        end else if (ho) m_valid = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        int          sel;
        x   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4) begin
            x[31:26] = 6'h00;
            if ($urandom_range(0, 1) == 1) x[5:0] = 6'h10 + 6'($urandom_range(0, 11));
        end else if (sel == 4) begin
            x[31:26] = 6'h01;
            x[20:16] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 1))
                                                   : 5'($urandom_range(16, 19));
        end else if (sel < 9) begin
            x[31:26] = 6'($urandom_range(0, 43));
        end
        return x;
    endfunction

    initial begin
        logic        r;
        logic        got;
        int          n;
        logic [31:0] rsv [3];

        rsv[0] = 32'hFC000000;
        rsv[1] = 32'h00000001;
        rsv[2] = 32'h04050000;

        build_tables();
        model_reset();

        // reset with ADDIU held valid
        bus_if.in_valid  = 1'b1;
        bus_if.instr     = I_ADDIU;
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b1;
        resetn           = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_busy",      32'(bus_if.hilo_busy), 32'd0);
        check("rst_ctrl",      32'(obs_word()),       32'd0);
        resetn = 1'b1;
        step(1'b1, I_ADDIU, 1'b0, 1'b1, r);
        check("addiu_ready", 32'(r), 32'd1);
        check("addiu_valid",  32'(bus_if.out_valid), 32'd1);
        check("addiu_alusrc", 32'(bus_if.alusrc),    32'h1);
        check("addiu_rw",     32'(bus_if.regwrite),  32'd1);
        check("addiu_ri",     32'(bus_if.ri),        32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1, r);

        // back-pressure: second instruction held, both emerge in order
        step(1'b1, I_ORI, 1'b0, 1'b0, r);
        step(1'b1, I_SW,  1'b0, 1'b0, r);
        check("b2b_hold0", 32'(r), 32'd0);
        step(1'b1, I_SW,  1'b0, 1'b0, r);
        check("b2b_hold1", 32'(r), 32'd0);
        step(1'b1, I_SW,  1'b0, 1'b1, r);
        check("b2b_take", 32'(r), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, r);
        step(1'b0, 32'h0, 1'b0, 1'b1, r);

        // DIV then dependent MFLO, with an unrelated ADDU slipping through
        step(1'b1, I_DIV,  1'b0, 1'b1, r);
        step(1'b1, I_MFLO, 1'b0, 1'b1, r);
        check("mflo_pre", 32'(r), 32'd0);
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            n++;
            if (i == 5) begin
                step(1'b1, I_ADDU, 1'b0, 1'b1, r);
                check("addu_unstalled", 32'(r), 32'd1);
            end else begin
                step(1'b1, I_MFLO, 1'b0, 1'b1, r);
                if (r) got = 1'b1;
            end
        end
        check("mflo_accepted", 32'(got), 32'd1);
        check("mflo_latency",  32'(n),   32'd35);
        step(1'b0, 32'h0, 1'b0, 1'b1, r);

        // flush wins over in_valid and out_ready
        step(1'b1, I_ADDU, 1'b0, 1'b0, r);
        step(1'b1, I_MULT, 1'b1, 1'b1, r);
        check("flush_blocks", 32'(r), 32'd0);
        check("flush_ov", 32'(bus_if.out_valid), 32'd0);
        step(1'b1, I_MULT, 1'b0, 1'b1, r);
        step(1'b0, 32'h0,  1'b1, 1'b1, r);
        check("flushed_mult_busy", 32'(bus_if.hilo_busy), 32'd0);
        step(1'b1, I_MFHI, 1'b0, 1'b1, r);
        check("mfhi_free", 32'(r), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, r);

        // reserved encodings
        for (int k = 0; k < 3; k++) begin
            step(1'b1, rsv[k], 1'b0, 1'b1, r);
            check("rsv_ri",     32'(bus_if.ri),         32'd1);
            check("rsv_others", 32'(obs_word() >> 1),   32'd0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, r);

        // asynchronous reset while the counter sits at 20
        step(1'b1, I_DIV, 1'b0, 1'b1, r);
        step(1'b0, 32'h0, 1'b0, 1'b1, r);
        repeat (13) step(1'b0, 32'h0, 1'b0, 1'b1, r);
        step(1'b1, I_ADDU, 1'b0, 1'b0, r);
        check("pre_rst_busy", 32'(bus_if.hilo_busy), 32'd1);
        check("pre_rst_ov",   32'(bus_if.out_valid), 32'd1);
        bus_if.in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy",  32'(bus_if.hilo_busy), 32'd0);
        check("arst_ov",    32'(bus_if.out_valid), 32'd0);
        check("arst_ready", 32'(bus_if.in_ready),  32'd1);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), rand_instr(),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) < 7), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
